talon_stock_ctrl: RTL and testbench

TALON_STOCK_CTRL -- requirements
Module: talon_stock_ctrl

---
 rtl/talon_stock_ctrl.sv | 131 +++++++++++++
 tb/tb_talon_stock_ctrl.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/talon_stock_ctrl.sv
// talon_stock_ctrl: talon/stock card pile controller with draw, recycle and take.
module talon_stock_ctrl #(
    parameter int CARD_W     = 7,
    parameter int DEPTH      = 24,
    parameter int DRAW_N     = 1,
    parameter int MAX_PASSES = 0,
    localparam int SIZE_W    = $clog2(DEPTH + 1)
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_load_valid,
    input  logic [DEPTH*CARD_W-1:0] i_load_pile,
    input  logic [SIZE_W-1:0]       i_load_size,
    input  logic                    i_cmd_valid,
    input  logic [1:0]              i_cmd,
    output logic                    o_cmd_ready,
    output logic                    o_done,
    output logic                    o_err,
    output logic [CARD_W-1:0]       o_taken_card,
    output logic [CARD_W-1:0]       o_top_card,
    output logic [SIZE_W-1:0]       o_talon_size,
    output logic [SIZE_W-1:0]       o_stock_size,
    output logic [7:0]              o_pass_count
);
    typedef enum logic [2:0] {IDLE, DRAW, RECYCLE, TAKE, DONE} state_t;
    state_t            r_state, w_state_next;
    logic [CARD_W-1:0] r_talon [DEPTH];
    logic [CARD_W-1:0] r_stock [DEPTH];
    logic [SIZE_W-1:0] r_talon_size, r_stock_size, r_cnt;
    logic [7:0]        r_pass;
    logic              r_err;
    logic [CARD_W-1:0] r_taken, r_top;
    logic              w_load, w_err, w_pass_ok, w_draw_last;
    logic [CARD_W-1:0] w_talon_top, w_stock_top, w_stock_below;
    assign w_load        = (r_state == IDLE) && i_load_valid;
    assign w_pass_ok     = (MAX_PASSES == 0) || (32'(r_pass) < MAX_PASSES);
    assign w_draw_last   = (r_cnt == SIZE_W'(DRAW_N - 1)) || (r_talon_size == SIZE_W'(1));
    assign w_talon_top   = r_talon[r_talon_size - SIZE_W'(1)];
    assign w_stock_top   = r_stock[r_stock_size - SIZE_W'(1)];
    assign w_stock_below = (r_stock_size > SIZE_W'(1)) ? r_stock[r_stock_size - SIZE_W'(2)] : '0;
    assign o_cmd_ready   = (r_state == IDLE) && !i_load_valid;
    assign o_done        = (r_state == DONE);
    assign o_err         = r_err;
    assign o_taken_card  = r_taken;
    assign o_top_card    = r_top;
    assign o_talon_size  = r_talon_size;
    assign o_stock_size  = r_stock_size;
    assign o_pass_count  = r_pass;
    always_comb begin
        w_state_next = r_state;
        w_err        = 1'b0;
        case (r_state)
            IDLE: begin
                if (o_cmd_ready && i_cmd_valid) begin
                    if (i_cmd == 2'b00 && r_talon_size != '0)
                        w_state_next = DRAW;
                    else if (i_cmd == 2'b00 && r_stock_size != '0 && w_pass_ok)
                        w_state_next = RECYCLE;
                    else if (i_cmd == 2'b01 && r_stock_size != '0)
                        w_state_next = TAKE;
                    else
                        w_err = 1'b1;
                end
            end
            DRAW:    w_state_next = w_draw_last ? DONE : DRAW;
            RECYCLE: w_state_next = (r_stock_size == SIZE_W'(1)) ? DONE : RECYCLE;
            TAKE:    w_state_next = DONE;
            default: w_state_next = IDLE;
        endcase
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_talon_size <= '0;
            r_stock_size <= '0;
            r_cnt        <= '0;
            r_pass       <= '0;
            r_err        <= 1'b0;
            r_taken      <= '0;
            r_top        <= '0;
        end else begin
            r_state <= w_state_next;
            r_err   <= w_err;
            if (w_load) begin
                r_talon_size <= (i_load_size > SIZE_W'(DEPTH)) ? SIZE_W'(DEPTH) : i_load_size;
                r_stock_size <= '0;
                r_pass       <= '0;
                r_top        <= '0;
            end
            if (r_state == IDLE)
                r_cnt <= '0;
            if (r_state == DRAW) begin
                r_talon_size <= r_talon_size - SIZE_W'(1);
                r_stock_size <= r_stock_size + SIZE_W'(1);
                r_cnt        <= r_cnt + SIZE_W'(1);
                r_top        <= w_talon_top;
            end
            if (r_state == RECYCLE) begin
                r_talon_size <= r_talon_size + SIZE_W'(1);
                r_stock_size <= r_stock_size - SIZE_W'(1);
                r_top        <= w_stock_below;
                if (r_stock_size == SIZE_W'(1))
                    r_pass <= (r_pass == 8'hFF) ? r_pass : r_pass + 8'd1;
            end
            if (r_state == TAKE) begin
                r_stock_size <= r_stock_size - SIZE_W'(1);
                r_taken      <= w_stock_top;
                r_top        <= w_stock_below;
            end
        end
    end
    // Pile contents need no reset: only entries below the size counters are ever read.
    always_ff @(posedge i_clk) begin
        if (w_load) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_talon[i] <= i_load_pile[i*CARD_W +: CARD_W];
                r_stock[i] <= '0;
            end
        end
        if (r_state == DRAW) begin
            r_stock[r_stock_size]              <= w_talon_top;
            r_talon[r_talon_size - SIZE_W'(1)] <= '0;
        end
        if (r_state == RECYCLE) begin
            r_talon[r_talon_size]              <= w_stock_top;
            r_stock[r_stock_size - SIZE_W'(1)] <= '0;
        end
        if (r_state == TAKE)
            r_stock[r_stock_size - SIZE_W'(1)] <= '0;
    end
endmodule

// File: tb/tb_talon_stock_ctrl.sv
// tb_talon_stock_ctrl: directed checks of a DRAW_N=1 instance (a_) and a DRAW_N=3, MAX_PASSES=1 instance (b_).
module tb_talon_stock_ctrl;
    localparam int CW = 7;
    localparam int D  = 24;
    localparam int SW = 5;
    logic           clk = 1'b0;
    logic           rst_n;
    logic           load_valid;
    logic [D*CW-1:0] load_pile;
    logic [SW-1:0]  load_size;
    logic           cmd_valid;
    logic [1:0]     cmd;
    logic           a_ready, a_done, a_err, b_ready, b_done, b_err;
    logic [CW-1:0]  a_taken, a_top, b_taken, b_top;
    logic [SW-1:0]  a_ts, a_ss, b_ts, b_ss;
    logic [7:0]     a_pass, b_pass;
    int             n_checks = 0;
    int             n_errors = 0;
    always #5 clk = ~clk;
    talon_stock_ctrl #(.CARD_W(CW), .DEPTH(D), .DRAW_N(1), .MAX_PASSES(0)) u_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_load_valid(load_valid), .i_load_pile(load_pile),
        .i_load_size(load_size), .i_cmd_valid(cmd_valid), .i_cmd(cmd), .o_cmd_ready(a_ready),
        .o_done(a_done), .o_err(a_err), .o_taken_card(a_taken), .o_top_card(a_top),
        .o_talon_size(a_ts), .o_stock_size(a_ss), .o_pass_count(a_pass));
    talon_stock_ctrl #(.CARD_W(CW), .DEPTH(D), .DRAW_N(3), .MAX_PASSES(1)) u_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_load_valid(load_valid), .i_load_pile(load_pile),
        .i_load_size(load_size), .i_cmd_valid(cmd_valid), .i_cmd(cmd), .o_cmd_ready(b_ready),
        .o_done(b_done), .o_err(b_err), .o_taken_card(b_taken), .o_top_card(b_top),
        .o_talon_size(b_ts), .o_stock_size(b_ss), .o_pass_count(b_pass));
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask
    task automatic tick();
        @(negedge clk);
    endtask
    task automatic do_load(input int size);
        load_valid = 1'b1;
        load_size  = SW'(size);
        tick();
        load_valid = 1'b0;
    endtask
    task automatic send(input logic [1:0] c);
        cmd_valid = 1'b1;
        cmd       = c;
        tick();
        cmd_valid = 1'b0;
    endtask
    initial begin
        rst_n = 1'b0; load_valid = 1'b0; load_pile = '0; load_size = '0; cmd_valid = 1'b0; cmd = 2'b00;
        repeat (2) tick();
        check("rst_ts", a_ts, 0); check("rst_ss", a_ss, 0); check("rst_pass", a_pass, 0);
        check("rst_done", a_done, 0); check("rst_err", a_err, 0);
        check("rst_taken", a_taken, 0); check("rst_top", a_top, 0);
        rst_n = 1'b1;
        tick();
        check("rst_ready", a_ready, 1);
        for (int i = 0; i < D; i++) load_pile[i*CW +: CW] = CW'(i + 1);
        do_load(24);
        check("load_ts", a_ts, 24); check("load_ss", a_ss, 0); check("load_top", a_top, 0);
        send(2'b00);
        check("draw1_c1_done", a_done, 0); check("draw1_c1_ready", a_ready, 0);
        tick();
        check("draw1_c2_done", a_done, 1); check("draw1_ts", a_ts, 23);
        check("draw1_ss", a_ss, 1); check("draw1_top", a_top, 24);
        tick();
        check("draw1_c3_done", a_done, 0); check("draw1_c3_ready", a_ready, 1);
        check("draw3_c3_done", b_done, 0);
        tick();
        check("draw3_c4_done", b_done, 1); check("draw3_top", b_top, 22); check("draw3_ts", b_ts, 21);
        repeat (2) tick();
        send(2'b01);
        check("take_c1_done", a_done, 0);
        tick();
        check("take_done", a_done, 1); check("take_card", a_taken, 24);
        check("take_ss", a_ss, 0); check("take_top", a_top, 0); check("take_ts", a_ts, 23);
        repeat (2) tick();
        send(2'b01);
        check("take_empty_err", a_err, 1); check("take_empty_ss", a_ss, 0);
        tick();
        check("take_empty_err_pulse", a_err, 0); check("take_empty_nodone", a_done, 0);
        repeat (2) tick();
        send(2'b10);
        check("rsv_err_a", a_err, 1); check("rsv_err_b", b_err, 1);
        repeat (2) tick();
        load_valid = 1'b1; load_size = 5'd31; cmd_valid = 1'b1; cmd = 2'b00;
        tick();
        load_valid = 1'b0; cmd_valid = 1'b0;
        check("clamp_ts", a_ts, 24); check("clamp_ss", a_ss, 0); check("clamp_pass", a_pass, 0);
        tick();
        check("prio_nodone", a_done, 0); check("prio_ts", a_ts, 24); check("prio_ready", a_ready, 1);
        load_pile = '0;
        load_pile[0*CW +: CW] = 7'd5;
        load_pile[1*CW +: CW] = 7'd9;
        do_load(2);
        check("b_load_ts", b_ts, 2);
        send(2'b00);
        check("b_draw_c1", b_done, 0);
        tick();
        check("b_draw_c2", b_done, 0);
        tick();
        check("b_draw_c3", b_done, 1); check("b_draw_top", b_top, 5);
        check("b_draw_ts", b_ts, 0); check("b_draw_ss", b_ss, 2);
        repeat (2) tick();
        send(2'b00);
        check("b_rec_c1", b_done, 0);
        tick();
        check("b_rec_c2", b_done, 0);
        tick();
        check("b_rec_c3", b_done, 1); check("b_rec_ts", b_ts, 2); check("b_rec_ss", b_ss, 0);
        check("b_rec_pass", b_pass, 1); check("b_rec_top", b_top, 0);
        repeat (2) tick();
        send(2'b00);
        repeat (2) tick();
        check("b_redraw_done", b_done, 1); check("b_redraw_top", b_top, 5);
        check("b_redraw_ts", b_ts, 0); check("b_redraw_ss", b_ss, 2);
        repeat (2) tick();
        send(2'b00);
        check("b_limit_err", b_err, 1); check("b_limit_ts", b_ts, 0);
        check("b_limit_ss", b_ss, 2); check("b_limit_pass", b_pass, 1);
        tick();
        check("b_limit_c2_done", b_done, 0); check("b_limit_c2_err", b_err, 0);
        tick();
        check("b_limit_c3_done", b_done, 0);
        repeat (2) tick();
        for (int i = 0; i < 5; i++) load_pile[i*CW +: CW] = CW'(10 + i);
        do_load(5);
        send(2'b00);
        tick();
        check("mid_ts", b_ts, 4); check("mid_ss", b_ss, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_ts", b_ts, 0); check("arst_ss", b_ss, 0); check("arst_top", b_top, 0);
        check("arst_done", b_done, 0); check("arst_ready", b_ready, 1);
        tick();
        rst_n = 1'b1;
        tick();
        do_load(3);
        check("post_rst_ts", b_ts, 3); check("post_rst_ss", b_ss, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
